// File: rtl/rv32i_pkg.sv
// Shared RV32I register-file definitions: datapath widths, the hard-wired
// zero register and the write-request record passed between the write-back
// requesters and the register file.
package rv32i_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // Ceiling of the saturating drop counter (8-bit).
  localparam logic [7:0] DROP_MAX = 8'hFF;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wr_req_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side write-back bus: packed valid/address/data from NUM_REQ
// requesters and the one-hot ready (grant) returned by the arbiter.
// The master modport is the requester side, the slave modport is the arbiter.
interface regfile_wr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int AW      = 5
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*AW-1:0]   req_addr;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans the N candidates starting just
// after index 'last' (wrapping modulo N) and returns a one-hot grant for the
// first valid one, or all-zero when nothing is valid. Passing last = N-1
// turns it into a plain lowest-index-first priority picker.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] last,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [PW-1:0] idx;

  // First valid candidate in wrap-around order after 'last' wins.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(last) + k) % N);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the RV32I 32x32 register file. Grants at most one
// requester per cycle (combinational ready), registers the winning write and
// presents it to the register file one cycle later. Writes to x0 are accepted
// and discarded, and counted in a saturating 8-bit drop counter.
// Build option: define REGFILE_ARB_RR_EN for round-robin arbitration with a
// 'last' pointer; left undefined the arbiter is fixed priority (lowest index).
module regfile_wr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = rv32i_pkg::XLEN,
  parameter int AW      = rv32i_pkg::REG_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_wr_arbiter_if.slave    req,
  input  logic                   rf_busy,
  output logic                   wr_en,
  output logic [AW-1:0]          wr_addr,
  output logic [XLEN-1:0]        wr_data,
  output logic [7:0]             drop_cnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ready;
  logic [PW-1:0]      search_from;
  logic               xfer;
  logic [AW-1:0]      sel_addr;
  logic [XLEN-1:0]    sel_data;
  logic               sel_is_zero;

`ifdef REGFILE_ARB_RR_EN
  logic [PW-1:0] last_q;
  logic [PW-1:0] sel_idx;
  assign search_from = last_q;
`else
  assign search_from = PW'(NUM_REQ - 1);
`endif

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .valid (req.req_valid),
    .last  (search_from),
    .grant (grant)
  );

  // Grant depends only on valid, busy, reset and the pointer, never on addr/data.
  assign ready         = (rst || rf_busy) ? '0 : grant;
  assign req.req_ready = ready;

  // Mux the granted requester's address/data onto the register input.
  always_comb begin
    xfer     = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ready[i] && req.req_valid[i]) begin
        xfer     = 1'b1;
        sel_addr = req.req_addr[i*AW +: AW];
        sel_data = req.req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign sel_is_zero = (sel_addr == AW'(rv32i_pkg::REG_ZERO));

  // Output register: issue non-x0 writes, hold addr/data otherwise, count x0 drops.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      drop_cnt <= '0;
    end else begin
      wr_en <= xfer && !sel_is_zero;
      if (xfer && !sel_is_zero) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
      if (xfer && sel_is_zero && (drop_cnt != rv32i_pkg::DROP_MAX)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

`ifdef REGFILE_ARB_RR_EN
  // Index of the requester that transfers this cycle (meaningful only when xfer).
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ready[i] && req.req_valid[i]) begin
        sel_idx = PW'(i);
      end
    end
  end

  // Pointer follows every transfer, x0 drops included; reset makes requester 0 first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= PW'(NUM_REQ - 1);
    end else if (xfer) begin
      last_q <= sel_idx;
    end
  end
`endif

endmodule
